fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction fetch queue between `prog_counter` and the decode stage of the 64-bit RISC-V pipeline. It captures each fetched (PC, instruction) pair into a small first-word-fall-through FIFO and presents the oldest entry to decode with a valid/ready handshake. It back-pressures `prog_counter` through its `stall` input when full, and discards all queued entries on a taken-branch flush.

## Interface
- `DEPTH`, 4: number of entries; power of two, at least 2.
- `ADDR_W`, 64: PC width.
- `INSTR_W`, 32: instruction width.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high; sampled on the rising edge of `clk`.
- `pc_in` input ADDR_W: PC of the instruction being fetched (driven from `prog_counter` `PC_Out`).
- `instr_in` input INSTR_W: instruction-memory read data for `pc_in` (combinational).
- `fetch_valid` input 1: `pc_in` / `instr_in` pair is valid this cycle.
- `pc_stall` output 1: queue full; drives `prog_counter` `stall`.
- `flush` input 1: taken branch or jump resolved; discard all entries.
- `dec_ready` input 1: decode accepts the head entry this cycle.
- `dec_valid` output 1: head entry valid.
- `dec_pc` output ADDR_W: PC of the head entry.
- `dec_instr` output INSTR_W: instruction of the head entry; NOP `32'h00000013` when `dec_valid` is 0.
- `count` output log2(DEPTH)+1: number of occupied entries.

## Operation
- Storage: DEPTH × (ADDR_W + INSTR_W) register array, with read pointer `rd_ptr` and write pointer `wr_ptr` of log2(DEPTH) bits each. Pointers wrap naturally from DEPTH-1 to 0. `count` is held in its own register.
- Definitions:
  - full = (count == DEPTH)
  - empty = (count == 0)
  - `pc_stall` = full
  - `dec_valid` = !empty
- Write enable: `we` = `fetch_valid` && !full. On `we`, store the pair at `wr_ptr` and increment `wr_ptr`.
- Read enable: `re` = `dec_valid` && `dec_ready`. On `re`, increment `rd_ptr`.
- Count update:
  - `we` && !`re`: count+1
  - `re` && !`we`: count−1
  - both or neither: unchanged
- Full with simultaneous read: the write is still blocked, because full is taken from the registered count. `prog_counter` is already stalled and re-presents the same PC next cycle.
- Empty with `fetch_valid`: the entry is written. There is no bypass; the entry appears on decode the next cycle.
- Flush priority: `flush` overrides `we` and `re`.
  - `rd_ptr`, `wr_ptr` and `count` are all set to 0.
  - The incoming pair in the flush cycle is dropped.
  - The head entry is not counted as consumed.
- Priority order: `reset` > `flush` > normal write/read.
- Storage contents are not cleared by reset or flush. Only pointers and count are reset.

## Timing
- Reset values after the reset edge:
  - `count` = 0, `pc_stall` = 0, `dec_valid` = 0
  - `dec_pc` = 0, `dec_instr` = NOP
- Fill latency: a pair written at edge N is visible on `dec_*` in the cycle after edge N (1-cycle latency).
- Fall-through: `dec_pc` and `dec_instr` are combinational reads of the head entry; gate to 0 / NOP when empty. No combinational path from `dec_ready` to any output.
- Stall timing: `pc_stall` rises in the cycle after the edge that filled the last entry. It falls in the cycle after the first read from a full queue.
- Throughput: one write and one read per cycle sustained when not full.
- Reset mid-operation: state after the reset edge is identical to power-up, independent of `flush`, `fetch_valid` and `dec_ready`.

## Structure
- Shared constants go in the shared include file:
  - NOP encoding `32'h00000013`
  - ADDR_W and INSTR_W defaults
- Sub-module `fq_storage`: the register array with one write port and one asynchronous read port, parameterised on DEPTH and data width.
- Pointer, count and control logic live in the top-level `fetch_queue`.

## Test plan
- Reset: hold `reset` 2 cycles with `fetch_valid`=1 → `count`=0, `dec_valid`=0, `dec_instr`=`32'h00000013`, `pc_stall`=0.
- Fill: `dec_ready`=0; write PCs 0x0, 0x4, 0x8, 0xC → `count`=4 and `pc_stall`=1 after the 4th edge; a 5th pair at PC 0x10 is not stored.
- Drain order: from full, `dec_ready`=1 for 4 cycles → `dec_pc` shows 0x0, 0x4, 0x8, 0xC on consecutive cycles, then `dec_valid`=0.
- Wrap-around: stream 10 writes with simultaneous reads at steady count 2 → every PC emerges in order with no loss or duplication across pointer wrap.
- Flush: `count`=3 with `fetch_valid`=1 and `dec_ready`=1 in the same cycle as `flush` → next cycle `count`=0, `dec_valid`=0; the next write (PC 0x100) appears at the head.
- Full with read: `count`=4, `dec_ready`=1, `fetch_valid`=1 → next cycle `count`=3, `pc_stall`=0, and the incoming pair is not stored.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// fetch_queue_pkg
//   Shared constants for the instruction fetch queue. The fetch queue, its bus
//   interface and the bench import these values.
//
//   NOP_INSTR   : RV64I canonical NOP (addi x0, x0, 0). Decode sees it when the
//                 queue is empty.
//   ADDR_W_DEF  : default PC width.
//   INSTR_W_DEF : default instruction width.
//   DEPTH_DEF   : default number of queue entries.
// -----------------------------------------------------------------------------
package fetch_queue_pkg;

  localparam int ADDR_W_DEF  = 64;
  localparam int INSTR_W_DEF = 32;
  localparam int DEPTH_DEF   = 4;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Builds the instruction shown to decode. An empty queue presents a NOP
  // instead of stale storage contents.
  function automatic logic [INSTR_W_DEF-1:0] gate_instr(
    input logic                   valid,
    input logic [INSTR_W_DEF-1:0] instr
  );
    return valid ? instr : NOP_INSTR;
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// -----------------------------------------------------------------------------
// fetch_queue_if
//   Bundles the fetch-side and decode-side signals of the fetch queue.
//
//   Fetch side : pc_in, instr_in, fetch_valid (into the queue)
//                pc_stall (out, back-pressure to prog_counter)
//   Control    : flush (into the queue, taken branch/jump)
//   Decode side: dec_ready (into the queue)
//                dec_valid, dec_pc, dec_instr (out, head entry)
//   Status     : count (out, occupied entries)
//
//   master : the environment, which is fetch plus decode
//   slave  : the fetch queue itself
// -----------------------------------------------------------------------------
interface fetch_queue_if
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0]  pc_in;
  logic [INSTR_W-1:0] instr_in;
  logic               fetch_valid;
  logic               pc_stall;
  logic               flush;
  logic               dec_ready;
  logic               dec_valid;
  logic [ADDR_W-1:0]  dec_pc;
  logic [INSTR_W-1:0] dec_instr;
  logic [CNT_W-1:0]   count;

  modport master (
    output pc_in,
    output instr_in,
    output fetch_valid,
    output flush,
    output dec_ready,
    input  pc_stall,
    input  dec_valid,
    input  dec_pc,
    input  dec_instr,
    input  count
  );

  modport slave (
    input  pc_in,
    input  instr_in,
    input  fetch_valid,
    input  flush,
    input  dec_ready,
    output pc_stall,
    output dec_valid,
    output dec_pc,
    output dec_instr,
    output count
  );

endinterface

// File: rtl/fetch_queue_storage.sv
// -----------------------------------------------------------------------------
// fq_storage
//   Register array for the fetch queue. It has one synchronous write port and
//   one asynchronous read port. Nothing clears the contents. Only the queue's
//   pointers decide which entries are live, so no reset is needed here.
//
//   i_clk   : clock
//   i_we    : write enable
//   i_waddr : write index
//   i_wdata : write data
//   i_raddr : read index
//   o_rdata : read data for i_raddr (combinational)
// -----------------------------------------------------------------------------
module fq_storage #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 96,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [PTR_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [PTR_W-1:0]  i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Instruction fetch queue between prog_counter and decode. It is a
//   first-word-fall-through FIFO of (PC, instruction) pairs.
//   - pc_stall asserts while the queue is full. It drives the prog_counter
//     stall input.
//   - The oldest entry is presented to decode with a valid/ready handshake.
//     dec_pc and dec_instr are gated to 0 and NOP while the queue is empty.
//   - flush discards every queued entry, and also the pair offered in the
//     flush cycle.
//
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous, active-high
//   fq    : fetch_queue_if.slave (see the interface for the signal list)
// -----------------------------------------------------------------------------
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  fetch_queue_if.slave fq
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int DATA_W = ADDR_W + INSTR_W;

  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_full;
  logic              w_empty;
  logic              w_we;
  logic              w_re;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_head;
  logic [ADDR_W-1:0] w_head_pc;
  logic [INSTR_W-1:0] w_head_instr;

  // full and empty come from the registered count. A read in the same cycle
  // therefore cannot free a slot for that cycle's write. prog_counter is
  // already stalled and offers the same PC again.
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

  // A flush drops both the incoming pair and the head entry. The head entry
  // is not counted as consumed, so flush masks both enables.
  assign w_we = fq.fetch_valid && !w_full  && !fq.flush && !reset;
  assign w_re = fq.dec_ready   && !w_empty && !fq.flush;

  assign w_wdata = {fq.pc_in, fq.instr_in};

  fq_storage #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_storage (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wdata),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_head)
  );

  assign w_head_pc    = w_head[DATA_W-1:INSTR_W];
  assign w_head_instr = w_head[INSTR_W-1:0];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset || fq.flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_we) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_re) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_we && !w_re) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_re && !w_we) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // Outputs depend only on registered state. dec_ready has no combinational
  // path to any of them.
  assign fq.pc_stall  = w_full;
  assign fq.dec_valid = !w_empty;
  assign fq.dec_pc    = w_empty ? '0 : w_head_pc;
  assign fq.dec_instr = gate_instr(!w_empty, w_head_instr);
  assign fq.count     = r_count;

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
//   Directed bench for fetch_queue. Expected values are written by hand from
//   the queue's behaviour. Each instruction word is a fixed function of its
//   PC, so a pair can be checked end to end.
// -----------------------------------------------------------------------------
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH   = 4;
  localparam int ADDR_W  = 64;
  localparam int INSTR_W = 32;

  logic clk;
  logic reset;

  int n_vec;
  int n_err;

  fetch_queue_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) fq_bus ();

  fetch_queue #(
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .fq    (fq_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [63:0] pc);
    return 32'hA500_0000 ^ pc[31:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Advances one rising edge. Outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [63:0] pc);
    fq_bus.pc_in       = pc;
    fq_bus.instr_in    = instr_of(pc);
    fq_bus.fetch_valid = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    fq_bus.flush       = 1'b0;
    fq_bus.dec_ready   = 1'b0;
    offer(64'h40);

    // Reset held two cycles while fetch_valid is high
    step();
    step();
    chk("rst_count",  64'(fq_bus.count),     64'd0);
    chk("rst_valid",  64'(fq_bus.dec_valid), 64'd0);
    chk("rst_instr",  64'(fq_bus.dec_instr), 64'h13);
    chk("rst_stall",  64'(fq_bus.pc_stall),  64'd0);
    chk("rst_pc",     fq_bus.dec_pc,         64'd0);

    // Fill with decode stalled
    reset = 1'b0;
    offer(64'h0);
    step();
    chk("fill1_valid", 64'(fq_bus.dec_valid), 64'd1);
    chk("fill1_pc",    fq_bus.dec_pc,         64'h0);
    chk("fill1_instr", 64'(fq_bus.dec_instr), 64'(instr_of(64'h0)));
    offer(64'h4);  step();
    offer(64'h8);  step();
    chk("fill3_stall", 64'(fq_bus.pc_stall), 64'd0);
    offer(64'hC);  step();
    chk("fill4_count", 64'(fq_bus.count),    64'd4);
    chk("fill4_stall", 64'(fq_bus.pc_stall), 64'd1);
    offer(64'h10); step();
    chk("fill5_count", 64'(fq_bus.count),    64'd4);
    chk("fill5_head",  fq_bus.dec_pc,        64'h0);

    // Drain from full
    fq_bus.fetch_valid = 1'b0;
    fq_bus.dec_ready   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d_pc", i), fq_bus.dec_pc, 64'(4 * i));
      step();
      if (i == 0) begin
        chk("drain_stall_fall", 64'(fq_bus.pc_stall), 64'd0);
        chk("drain_count3",     64'(fq_bus.count),    64'd3);
      end
    end
    chk("drain_empty", 64'(fq_bus.dec_valid), 64'd0);
    chk("drain_nop",   64'(fq_bus.dec_instr), 64'h13);
    chk("drain_pc0",   fq_bus.dec_pc,         64'd0);

    // Full with a simultaneous read: the write is blocked
    fq_bus.dec_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      offer(64'h20 + 64'(4 * i));
      step();
    end
    chk("fr_full", 64'(fq_bus.pc_stall), 64'd1);
    fq_bus.dec_ready = 1'b1;
    offer(64'h30);
    step();
    chk("fr_count", 64'(fq_bus.count),    64'd3);
    chk("fr_stall", 64'(fq_bus.pc_stall), 64'd0);
    chk("fr_head",  fq_bus.dec_pc,        64'h24);
    fq_bus.fetch_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("fr_drain%0d", i), fq_bus.dec_pc, 64'h24 + 64'(4 * i));
      step();
    end
    chk("fr_not_stored", 64'(fq_bus.dec_valid), 64'd0);

    // Wrap-around: stream at a steady count of 2
    fq_bus.dec_ready = 1'b0;
    offer(64'h200); step();
    offer(64'h204); step();
    chk("wrap_pre_count", 64'(fq_bus.count), 64'd2);
    fq_bus.dec_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      offer(64'h208 + 64'(4 * i));
      chk($sformatf("wrap%0d_pc", i),    fq_bus.dec_pc,         64'h200 + 64'(4 * i));
      chk($sformatf("wrap%0d_instr", i), 64'(fq_bus.dec_instr), 64'(instr_of(64'h200 + 64'(4 * i))));
      step();
      chk($sformatf("wrap%0d_count", i), 64'(fq_bus.count), 64'd2);
    end
    fq_bus.fetch_valid = 1'b0;
    chk("wrap_tail0", fq_bus.dec_pc, 64'h228);
    step();
    chk("wrap_tail1", fq_bus.dec_pc, 64'h22C);
    step();
    chk("wrap_empty", 64'(fq_bus.dec_valid), 64'd0);

    // Flush with write and read offered in the same cycle
    fq_bus.dec_ready = 1'b0;
    offer(64'h300); step();
    offer(64'h304); step();
    offer(64'h308); step();
    chk("fl_pre_count", 64'(fq_bus.count), 64'd3);
    fq_bus.flush     = 1'b1;
    fq_bus.dec_ready = 1'b1;
    offer(64'h30C);
    step();
    chk("fl_count", 64'(fq_bus.count),     64'd0);
    chk("fl_valid", 64'(fq_bus.dec_valid), 64'd0);
    fq_bus.flush     = 1'b0;
    fq_bus.dec_ready = 1'b0;
    offer(64'h100);
    step();
    chk("fl_next_pc",    fq_bus.dec_pc,         64'h100);
    chk("fl_next_instr", 64'(fq_bus.dec_instr), 64'(instr_of(64'h100)));
    chk("fl_next_count", 64'(fq_bus.count),     64'd1);

    // Reset mid-operation overrides flush, fetch and read
    offer(64'h104);
    step();
    chk("mid_pre_count", 64'(fq_bus.count), 64'd2);
    reset            = 1'b1;
    fq_bus.flush     = 1'b1;
    fq_bus.dec_ready = 1'b1;
    offer(64'h108);
    step();
    chk("mid_count", 64'(fq_bus.count),     64'd0);
    chk("mid_valid", 64'(fq_bus.dec_valid), 64'd0);
    chk("mid_pc",    fq_bus.dec_pc,         64'd0);
    chk("mid_instr", 64'(fq_bus.dec_instr), 64'h13);
    chk("mid_stall", 64'(fq_bus.pc_stall),  64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
